// File: rtl/fft_test.sv
// ---------------------------------------------------------------------------
// fft_test
//
// Burst-mode radix-2 decimation-in-time complex FFT for the audio spectrum
// path. A frame of N samples is captured (written to bit-reversed addresses),
// transformed in place one butterfly per clock with a 1/2 scale per stage,
// then streamed out as N bins in natural order with sop/eop framing.
//
// Frame timing: N load cycles, (N/2)*LOG2N compute cycles, N output cycles.
//
// Ports
//   clk           single clock, everything on the rising edge
//   reset         synchronous, active-low reset
//   sink_real     input sample, real part (signed Q1.23)
//   sink_imag     input sample, imaginary part (signed Q1.23)
//   sink_ready    high = the sample on sink_* is captured at this edge
//   source_error  error code, always 2'b00
//   source_valid  source_real/imag/exp hold a valid bin
//   source_sop    high with bin 0 of a frame
//   source_eop    high with bin N-1 of a frame
//   source_real   bin real part
//   source_imag   bin imaginary part
//   source_exp    block exponent, -LOG2N while valid (bins are DFT/N)
// ---------------------------------------------------------------------------
module fft_test #(
   parameter int LOG2N = 4,
   parameter int DW    = 24,
   parameter int TW    = 24
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] sink_real,
   input  logic [DW-1:0] sink_imag,
   output logic          sink_ready,
   output logic [1:0]    source_error,
   output logic          source_valid,
   output logic          source_sop,
   output logic          source_eop,
   output logic [DW-1:0] source_real,
   output logic [DW-1:0] source_imag,
   output logic [5:0]    source_exp
);

   localparam int N  = 1 << LOG2N;
   localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;
   localparam int BW = (LOG2N > 1) ? LOG2N - 1 : 1;
   localparam int PW = DW + TW;

   localparam logic [5:0]          EXP_VAL    = 6'(-LOG2N);
   localparam logic signed [PW:0]  ROUND_BIAS = (PW+1)'(1) << (TW-2);

   // Twiddle ROM for N=16, k=0..7, Q1.23. W(k) = cos - j*sin, so the
   // table holds +cos and +sin; +1.0 is saturated to the largest code.
   localparam logic [23:0] COS_ROM [8] = '{
      24'h7FFFFF, 24'h7641AF, 24'h5A827A, 24'h30FBC5,
      24'h000000, 24'hCF043B, 24'hA57D86, 24'h89BE51
   };
   localparam logic [23:0] SIN_ROM [8] = '{
      24'h000000, 24'h30FBC5, 24'h5A827A, 24'h7641AF,
      24'h7FFFFF, 24'h7641AF, 24'h5A827A, 24'h30FBC5
   };

   typedef enum logic [1:0] {
      LOAD,
      COMPUTE,
      OUTPUT
   } stateType;

   stateType state;

   logic [LOG2N-1:0] loadCnt;
   logic [SW-1:0]    stageCnt;
   logic [BW-1:0]    bflyCnt;
   logic [LOG2N-1:0] outCnt;

   // Working storage: a plain register array so the butterfly can read both
   // operands combinationally and write both results at the same edge.
   logic signed [DW-1:0] ramRe [N];
   logic signed [DW-1:0] ramIm [N];

   logic [LOG2N-1:0] bflyExt;
   logic [LOG2N-1:0] halfBit;
   logic [LOG2N-1:0] halfMask;
   logic [LOG2N-1:0] aIdx;
   logic [LOG2N-1:0] bIdx;
   logic [BW-1:0]    twIdx;

   logic signed [TW-1:0] twCos;
   logic signed [TW-1:0] twSin;
   logic signed [DW-1:0] aRe;
   logic signed [DW-1:0] aIm;
   logic signed [DW-1:0] bRe;
   logic signed [DW-1:0] bIm;
   logic signed [PW-1:0] pCosRe;
   logic signed [PW-1:0] pCosIm;
   logic signed [PW-1:0] pSinRe;
   logic signed [PW-1:0] pSinIm;
   logic signed [PW:0]   tReWide;
   logic signed [PW:0]   tImWide;
   logic signed [DW+1:0] tRe;
   logic signed [DW+1:0] tIm;
   logic signed [DW+1:0] sumRe;
   logic signed [DW+1:0] sumIm;
   logic signed [DW+1:0] difRe;
   logic signed [DW+1:0] difIm;
   logic signed [DW-1:0] newARe;
   logic signed [DW-1:0] newAIm;
   logic signed [DW-1:0] newBRe;
   logic signed [DW-1:0] newBIm;

   // Reverses the bit order of a sample index so that the natural-order
   // input lands where the in-place DIT algorithm expects it.
   function automatic logic [LOG2N-1:0] bitRev(input logic [LOG2N-1:0] v);
      logic [LOG2N-1:0] r;
      r = '0;
      for (int i = 0; i < LOG2N; i++) begin
         r[i] = v[LOG2N-1-i];
      end
      return r;
   endfunction

   // Butterfly addressing. Within stage s the butterfly counter splits into
   // a group number (bits >= s) and a position inside the group (bits < s).
   // The group bits are shifted up by one to leave room for the pair
   // distance 2^s, which becomes the b operand offset. The twiddle index is
   // the in-group position scaled by N/2^(s+1).
   always_comb begin
      bflyExt  = LOG2N'(bflyCnt);
      halfBit  = LOG2N'(1) << stageCnt;
      halfMask = halfBit - LOG2N'(1);
      aIdx     = ((bflyExt & ~halfMask) << 1) | (bflyExt & halfMask);
      bIdx     = aIdx | halfBit;
      twIdx    = BW'(bflyExt & halfMask) << (SW'(LOG2N-1) - stageCnt);
   end

   // Butterfly datapath. The complex product W*b uses full-precision
   // products, rounds to nearest and drops the Q1.23 fraction; the sum and
   // difference are formed two bits wider and then halved so every stage
   // carries its own 1/2 scale and nothing can overflow.
   always_comb begin
      twCos   = $signed(COS_ROM[twIdx]);
      twSin   = $signed(SIN_ROM[twIdx]);
      aRe     = ramRe[aIdx];
      aIm     = ramIm[aIdx];
      bRe     = ramRe[bIdx];
      bIm     = ramIm[bIdx];

      pCosRe  = PW'(twCos) * PW'(bRe);
      pCosIm  = PW'(twCos) * PW'(bIm);
      pSinRe  = PW'(twSin) * PW'(bRe);
      pSinIm  = PW'(twSin) * PW'(bIm);

      // (c - js)(br + j bi) = (c*br + s*bi) + j(c*bi - s*br)
      tReWide = (PW+1)'(pCosRe) + (PW+1)'(pSinIm) + ROUND_BIAS;
      tImWide = (PW+1)'(pCosIm) - (PW+1)'(pSinRe) + ROUND_BIAS;
      tRe     = (DW+2)'(tReWide >>> (TW-1));
      tIm     = (DW+2)'(tImWide >>> (TW-1));

      sumRe   = (DW+2)'(aRe) + tRe;
      sumIm   = (DW+2)'(aIm) + tIm;
      difRe   = (DW+2)'(aRe) - tRe;
      difIm   = (DW+2)'(aIm) - tIm;

      newARe  = DW'(sumRe >>> 1);
      newAIm  = DW'(sumIm >>> 1);
      newBRe  = DW'(difRe >>> 1);
      newBIm  = DW'(difIm >>> 1);
   end

   // Data memory writes. Samples go to bit-reversed addresses while loading;
   // during compute each edge retires one butterfly in place. The memory is
   // deliberately not cleared by reset, only writes are suppressed.
   always_ff @(posedge clk) begin
      if (reset) begin
         if (state == LOAD) begin
            ramRe[bitRev(loadCnt)] <= sink_real;
            ramIm[bitRev(loadCnt)] <= sink_imag;
         end else if (state == COMPUTE) begin
            ramRe[aIdx] <= newARe;
            ramIm[aIdx] <= newAIm;
            ramRe[bIdx] <= newBRe;
            ramIm[bIdx] <= newBIm;
         end
      end
   end

   // Frame sequencer with registered handshake and output bus. The last
   // butterfly never touches address 0, so bin 0 can be registered onto the
   // output bus on the same edge that finishes the transform.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= LOAD;
         loadCnt      <= '0;
         stageCnt     <= '0;
         bflyCnt      <= '0;
         outCnt       <= '0;
         sink_ready   <= 1'b1;
         source_error <= 2'b00;
         source_valid <= 1'b0;
         source_sop   <= 1'b0;
         source_eop   <= 1'b0;
         source_real  <= '0;
         source_imag  <= '0;
         source_exp   <= '0;
      end else begin
         source_error <= 2'b00;
         case (state)
            LOAD: begin
               loadCnt <= loadCnt + LOG2N'(1);
               if (loadCnt == LOG2N'(N-1)) begin
                  state      <= COMPUTE;
                  sink_ready <= 1'b0;
                  stageCnt   <= '0;
                  bflyCnt    <= '0;
               end
            end
            COMPUTE: begin
               bflyCnt <= bflyCnt + BW'(1);
               if (bflyCnt == BW'(N/2-1)) begin
                  stageCnt <= stageCnt + SW'(1);
                  if (stageCnt == SW'(LOG2N-1)) begin
                     state        <= OUTPUT;
                     source_valid <= 1'b1;
                     source_sop   <= 1'b1;
                     source_eop   <= 1'b0;
                     source_exp   <= EXP_VAL;
                     source_real  <= ramRe[0];
                     source_imag  <= ramIm[0];
                     outCnt       <= LOG2N'(1);
                  end
               end
            end
            OUTPUT: begin
               if (source_eop) begin
                  state        <= LOAD;
                  source_valid <= 1'b0;
                  source_sop   <= 1'b0;
                  source_eop   <= 1'b0;
                  source_exp   <= '0;
                  sink_ready   <= 1'b1;
                  loadCnt      <= '0;
               end else begin
                  source_real <= ramRe[outCnt];
                  source_imag <= ramIm[outCnt];
                  source_sop  <= 1'b0;
                  source_eop  <= (outCnt == LOG2N'(N-1));
                  outCnt      <= outCnt + LOG2N'(1);
               end
            end
            default: begin
               state <= LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fft_test.sv
// ---------------------------------------------------------------------------
// tb_fft_test
//
// Directed bench for fft_test. Each frame's expected bins are computed from a
// floating-point DFT of the driven samples (divided by N) and pushed to a
// scoreboard queue; they are popped as the DUT streams bins out and compared
// within a per-frame tolerance. Framing, latency and reset behaviour are
// checked against fixed values.
// ---------------------------------------------------------------------------
module tb_fft_test;

   localparam int  N  = 16;
   localparam real PI = 3.14159265358979;

   logic        clk = 1'b0;
   logic        reset;
   logic [23:0] sinkReal;
   logic [23:0] sinkImag;
   logic        sinkReady;
   logic [1:0]  sourceError;
   logic        sourceValid;
   logic        sourceSop;
   logic        sourceEop;
   logic [23:0] sourceReal;
   logic [23:0] sourceImag;
   logic [5:0]  sourceExp;

   typedef struct {
      int re;
      int im;
      int tol;
   } expBin_t;

   expBin_t sbQueue[$];
   int      sampRe [N];
   int      sampIm [N];
   int      assertCount = 0;
   int      failCount   = 0;

   fft_test #(.LOG2N(4), .DW(24), .TW(24)) dut (
      .clk          (clk),
      .reset        (reset),
      .sink_real    (sinkReal),
      .sink_imag    (sinkImag),
      .sink_ready   (sinkReady),
      .source_error (sourceError),
      .source_valid (sourceValid),
      .source_sop   (sourceSop),
      .source_eop   (sourceEop),
      .source_real  (sourceReal),
      .source_imag  (sourceImag),
      .source_exp   (sourceExp)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Hard stop in case the DUT never produces the expected handshakes.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: time limit reached before summary");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int roundReal(input real v);
      if (v >= 0.0) return $rtoi(v + 0.5);
      else return -$rtoi(-v + 0.5);
   endfunction

   task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $display("[TB] FAIL %s: observed %0d required %0d", tag, observed, expected);
         $error("[TB] %s check did not hold", tag);
      end
   endtask

   task automatic checkNear(input string tag, input int observed, input int expected, input int tol);
      int  diff;
      logic ok;
      diff = observed - expected;
      ok   = (diff <= tol) && (diff >= -tol);
      assertCount++;
      assert (ok === 1'b1) else begin
         failCount++;
         $display("[TB] FAIL %s: observed %0d required %0d +/- %0d", tag, observed, expected, tol);
         $error("[TB] %s out of tolerance", tag);
      end
   endtask

   task automatic checkResetState(input string name);
      checkEq({name, " valid"}, 32'(sourceValid), 32'd0);
      checkEq({name, " sop"},   32'(sourceSop),   32'd0);
      checkEq({name, " eop"},   32'(sourceEop),   32'd0);
      checkEq({name, " real"},  32'(sourceReal),  32'd0);
      checkEq({name, " imag"},  32'(sourceImag),  32'd0);
      checkEq({name, " exp"},   32'(sourceExp),   32'd0);
      checkEq({name, " error"}, 32'(sourceError), 32'd0);
      checkEq({name, " ready"}, 32'(sinkReady),   32'd1);
   endtask

   // Pushes the reference spectrum for the current sample arrays, then
   // drives the 16 samples on consecutive edges while counting sink_ready.
   task automatic applyStimulus(input string name, input int tol);
      real     accRe;
      real     accIm;
      real     th;
      int      readyHigh;
      expBin_t e;
      for (int k = 0; k < N; k++) begin
         accRe = 0.0;
         accIm = 0.0;
         for (int n = 0; n < N; n++) begin
            th    = 2.0 * PI * k * n / N;
            accRe = accRe + sampRe[n] * $cos(th) + sampIm[n] * $sin(th);
            accIm = accIm + sampIm[n] * $cos(th) - sampRe[n] * $sin(th);
         end
         e.re  = roundReal(accRe / N);
         e.im  = roundReal(accIm / N);
         e.tol = tol;
         sbQueue.push_back(e);
      end
      readyHigh = 0;
      for (int n = 0; n < N; n++) begin
         sinkReal = 24'(sampRe[n]);
         sinkImag = 24'(sampIm[n]);
         if (sinkReady === 1'b1) readyHigh++;
         @(posedge clk);
         #1;
      end
      sinkReal = '0;
      sinkImag = '0;
      checkEq({name, " ready-high cycles"}, 32'(readyHigh), 32'(N));
   endtask

   // Counts edges from the last sample edge to the first valid bin.
   task automatic waitOutput(input string name);
      int lat;
      int readyLeak;
      lat       = 0;
      readyLeak = 0;
      while (sourceValid !== 1'b1 && lat < 100) begin
         if (sinkReady !== 1'b0) readyLeak++;
         @(posedge clk);
         #1;
         lat++;
      end
      checkEq({name, " compute latency"}, 32'(lat), 32'd32);
      checkEq({name, " ready during compute"}, 32'(readyLeak), 32'd0);
   endtask

   // Checks numBins streamed bins against the scoreboard; a full frame also
   // checks the cycle after eop returns to loading.
   task automatic checkOutput(input string name, input int numBins);
      expBin_t e;
      for (int k = 0; k < numBins; k++) begin
         checkEq($sformatf("%s bin%0d scoreboard", name, k), 32'(sbQueue.size() > 0), 32'd1);
         if (sbQueue.size() > 0) e = sbQueue.pop_front();
         else begin
            e.re  = 0;
            e.im  = 0;
            e.tol = 0;
         end
         checkEq($sformatf("%s bin%0d valid", name, k), 32'(sourceValid), 32'd1);
         checkEq($sformatf("%s bin%0d sop", name, k),   32'(sourceSop),   32'(k == 0));
         checkEq($sformatf("%s bin%0d eop", name, k),   32'(sourceEop),   32'(k == N-1));
         checkEq($sformatf("%s bin%0d exp", name, k),   32'(sourceExp),   32'h3C);
         checkEq($sformatf("%s bin%0d error", name, k), 32'(sourceError), 32'd0);
         checkEq($sformatf("%s bin%0d ready", name, k), 32'(sinkReady),   32'd0);
         checkNear($sformatf("%s bin%0d real", name, k), int'($signed(sourceReal)), e.re, e.tol);
         checkNear($sformatf("%s bin%0d imag", name, k), int'($signed(sourceImag)), e.im, e.tol);
         @(posedge clk);
         #1;
      end
      if (numBins == N) begin
         checkEq({name, " after-eop valid"}, 32'(sourceValid), 32'd0);
         checkEq({name, " after-eop eop"},   32'(sourceEop),   32'd0);
         checkEq({name, " after-eop ready"}, 32'(sinkReady),   32'd1);
      end
   endtask

   initial begin
      reset    = 1'b0;
      sinkReal = '0;
      sinkImag = '0;
      repeat (10) @(posedge clk);
      #1;
      checkResetState("reset");
      reset = 1'b1;

      $display("[TB] DC frame");
      for (int n = 0; n < N; n++) begin
         sampRe[n] = 32'h100000;
         sampIm[n] = 0;
      end
      applyStimulus("dc", 2);
      waitOutput("dc");
      checkOutput("dc", N);

      $display("[TB] impulse frame");
      for (int n = 0; n < N; n++) begin
         sampRe[n] = (n == 0) ? 32'h400000 : 0;
         sampIm[n] = 0;
      end
      applyStimulus("impulse", 1);
      waitOutput("impulse");
      checkOutput("impulse", N);

      $display("[TB] cosine k=1 frame");
      for (int n = 0; n < N; n++) begin
         sampRe[n] = roundReal(4194304.0 * $cos(2.0 * PI * n / N));
         sampIm[n] = 0;
      end
      applyStimulus("cosine", 4);
      waitOutput("cosine");
      checkOutput("cosine", N);

      $display("[TB] full-scale negative frame");
      for (int n = 0; n < N; n++) begin
         sampRe[n] = -8388608;
         sampIm[n] = 0;
      end
      applyStimulus("negfs", 2);
      waitOutput("negfs");
      checkOutput("negfs", N);

      $display("[TB] reset during output");
      for (int n = 0; n < N; n++) begin
         sampRe[n] = 32'h100000;
         sampIm[n] = 0;
      end
      applyStimulus("abort", 2);
      waitOutput("abort");
      checkOutput("abort", 5);
      reset = 1'b0;
      @(posedge clk);
      #1;
      checkResetState("mid-output reset");
      reset = 1'b1;
      sbQueue.delete();

      $display("[TB] DC frame after reset");
      for (int n = 0; n < N; n++) begin
         sampRe[n] = 32'h0C0000;
         sampIm[n] = -32'h040000;
      end
      applyStimulus("recover", 2);
      waitOutput("recover");
      checkOutput("recover", N);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
